hmsg_source: RTL and testbench

- Transmitting counterpart of the null sink: emits a stream of fixed-destination messages on one output channel, using the 4-phase req/ack protocol.
- Payload is an incrementing counter. Every message carries a redundancy field.
- Used as a traffic generator in hgen_net test fabrics and as a filler endpoint. Pairs directly with a sink at DEST_ADDR.

---
 rtl/hmsg_source_pkg.sv | 27 ++
 rtl/hmsg_source_hack_debouncer.sv | 32 +++
 rtl/hmsg_source.sv | 134 +++++++++++++
 tb/tb_hmsg_source.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmsg_source_pkg.sv
// Shared constants, default channel widths and state encoding for the hmsg source endpoint.
package hmsg_source_pkg;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_REQ_CKS      = 2;

  localparam int HMSG_SENT_W = 32;

  typedef enum logic [2:0] {
    HMSG_SRC_ST_INIT = 3'd0,
    HMSG_SRC_ST_GAP  = 3'd1,
    HMSG_SRC_ST_REQ  = 3'd2,
    HMSG_SRC_ST_REL  = 3'd3,
    HMSG_SRC_ST_DONE = 3'd4
  } hmsg_src_st_e;

  // Bits needed to hold a counter ranging over 0 .. n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hmsg_source_hack_debouncer.sv
// Level filter for a handshake line: the output follows the raw input only after
// CKS consecutive samples disagree with the current filtered level.
module hack_debouncer
  import hmsg_source_pkg::*;
#(
  parameter int CKS = NS_REQ_CKS
) (
  input  logic gch_clk,
  input  logic gch_reset,
  input  logic raw,
  output logic ckd
);

  localparam int CW = cnt_w(CKS);

  logic [CW-1:0] run_cnt;

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      ckd     <= NS_OFF;
      run_cnt <= '0;
    end else if (raw == ckd) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(CKS - 1)) begin
      ckd     <= raw;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hmsg_source.sv
// Traffic generator: sends incrementing-payload messages to a fixed destination
// over a 4-phase req/ack channel, with a redundancy field and a sticky error port.
module hmsg_source
  import hmsg_source_pkg::*;
#(
  parameter int             MY_LOCAL_ADDR = 0,
  parameter int             DEST_ADDR     = 0,
  parameter int             ASZ           = NS_ADDRESS_SIZE,
  parameter int             DSZ           = NS_DATA_SIZE,
  parameter int             RSZ           = NS_REDUN_SIZE,
  parameter logic [DSZ-1:0] DATA_START    = '0,
  parameter int unsigned    NUM_MSGS      = 0,
  parameter int             GAP_CKS       = 1,
  parameter int             ACK_CKS       = NS_REQ_CKS
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  output logic           snd0_req_out,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           src_done,
  output logic           err0_error,
  output logic [ASZ-1:0] err0_src,
  output logic [DSZ-1:0] err0_dat
);

  localparam int             GW       = cnt_w(GAP_CKS + 1);
  localparam logic [ASZ-1:0] SRC_ADDR = ASZ'(MY_LOCAL_ADDR);
  localparam logic [ASZ-1:0] DST_ADDR = ASZ'(DEST_ADDR);

  // Redundancy is the address-salted payload sum, truncated to RSZ bits.
  function automatic logic [RSZ-1:0] red_of(input logic [DSZ-1:0] d);
    logic [DSZ-1:0] sum;
    sum = DSZ'(DEST_ADDR) + DSZ'(MY_LOCAL_ADDR) + d;
    return sum[RSZ-1:0];
  endfunction

  hmsg_src_st_e           state;
  logic                   ack_ckd;
  logic [GW-1:0]          gap_cnt;
  logic [HMSG_SENT_W-1:0] sent;
  logic [HMSG_SENT_W-1:0] sent_nxt;
  logic [DSZ-1:0]         dat_nxt;
  logic                   last_msg;

  assign dat_nxt  = snd0_dat + 1'b1;
  assign sent_nxt = sent + 1'b1;
  assign last_msg = (NUM_MSGS != 0) && (sent_nxt == NUM_MSGS);

  hack_debouncer #(
    .CKS(ACK_CKS)
  ) u_ack_deb (
    .gch_clk  (gch_clk),
    .gch_reset(gch_reset),
    .raw      (snd0_ack),
    .ckd      (ack_ckd)
  );

  always_ff @(posedge gch_clk) begin
    snd0_src <= SRC_ADDR;
    snd0_dst <= DST_ADDR;
    err0_src <= SRC_ADDR;
  end

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      state        <= HMSG_SRC_ST_INIT;
      gch_ready    <= NS_OFF;
      snd0_req_out <= NS_OFF;
      snd0_dat     <= DATA_START;
      snd0_red     <= red_of(DATA_START);
      src_done     <= NS_OFF;
      err0_error   <= NS_OFF;
      err0_dat     <= '0;
      gap_cnt      <= '0;
      sent         <= '0;
    end else begin
      case (state)
        HMSG_SRC_ST_INIT: begin
          gch_ready <= NS_ON;
          gap_cnt   <= '0;
          state     <= HMSG_SRC_ST_GAP;
        end
        HMSG_SRC_ST_GAP: begin
          if (ack_ckd) begin
            err0_error <= NS_ON;
            err0_dat   <= snd0_dat;
          end
          // A stuck-high ack holds the gap open so req never overlaps a live ack.
          if (gap_cnt == GW'(GAP_CKS)) begin
            if (!ack_ckd) begin
              snd0_req_out <= NS_ON;
              state        <= HMSG_SRC_ST_REQ;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        HMSG_SRC_ST_REQ: begin
          if (ack_ckd) begin
            snd0_req_out <= NS_OFF;
            state        <= HMSG_SRC_ST_REL;
          end
        end
        HMSG_SRC_ST_REL: begin
          if (!ack_ckd) begin
            snd0_dat <= dat_nxt;
            snd0_red <= red_of(dat_nxt);
            sent     <= sent_nxt;
            gap_cnt  <= '0;
            if (last_msg) begin
              src_done <= NS_ON;
              state    <= HMSG_SRC_ST_DONE;
            end else begin
              state <= HMSG_SRC_ST_GAP;
            end
          end
        end
        HMSG_SRC_ST_DONE: begin
          if (ack_ckd) begin
            err0_error <= NS_ON;
            err0_dat   <= snd0_dat;
          end
        end
        default: state <= HMSG_SRC_ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hmsg_source.sv
// Bench for hmsg_source: two differently configured sources, a cycle-level message
// lifecycle model checked every cycle, plus hand-computed literal expectations.
module tb_hmsg_source;

  logic       clk;
  logic       rst;
  logic       rdy    [2];
  logic       req    [2];
  logic       ack    [2];
  logic [7:0] src    [2];
  logic [7:0] dst    [2];
  logic [7:0] dat    [2];
  logic [3:0] red    [2];
  logic       done   [2];
  logic       err    [2];
  logic [7:0] esrc   [2];
  logic [7:0] edat   [2];

  logic       imm       [2];
  logic       force_en  [2];
  logic       force_val [2];
  logic       ack_reg   [2];
  logic       glitch    [2];

  int n_chk = 0;
  int n_err = 0;
  int rel_cyc = 0;

  int         rise_a [$];
  int         rise_b [$];
  logic [7:0] pay_a  [$];
  logic [3:0] rpay_a [$];

  // Model state, one slot per source instance.
  localparam int PH_INIT = 0, PH_IDLE = 1, PH_REQ = 2, PH_REL = 3, PH_DONE = 4;
  logic        m_valid = 1'b0;
  logic        m_ckd  [2];
  int          m_run  [2];
  int          m_ph   [2];
  int          m_idle [2];
  logic        m_req  [2];
  logic [7:0]  m_dat  [2];
  int unsigned m_sent [2];
  logic        m_done [2];
  logic        m_err  [2];
  logic [7:0]  m_edat [2];
  logic        m_rdy  [2];

  function automatic int p_my(input int i);    return (i == 0) ? 3 : 1;         endfunction
  function automatic int p_dst(input int i);   return (i == 0) ? 5 : 2;         endfunction
  function automatic int p_start(input int i); return (i == 0) ? 8'hFE : 8'h10; endfunction
  function automatic int p_num(input int i);   return (i == 0) ? 4 : 0;         endfunction
  function automatic int p_gap(input int i);   return (i == 0) ? 6 : 0;         endfunction
  function automatic int p_ack(input int i);   return (i == 0) ? 2 : 3;         endfunction

  hmsg_source #(
    .MY_LOCAL_ADDR(3), .DEST_ADDR(5), .ASZ(8), .DSZ(8), .RSZ(4),
    .DATA_START(8'hFE), .NUM_MSGS(4), .GAP_CKS(6), .ACK_CKS(2)
  ) u_dut_a (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(rdy[0]), .snd0_req_out(req[0]),
    .snd0_ack(ack[0]), .snd0_src(src[0]), .snd0_dst(dst[0]), .snd0_dat(dat[0]),
    .snd0_red(red[0]), .src_done(done[0]), .err0_error(err[0]), .err0_src(esrc[0]),
    .err0_dat(edat[0])
  );

  hmsg_source #(
    .MY_LOCAL_ADDR(1), .DEST_ADDR(2), .ASZ(8), .DSZ(8), .RSZ(4),
    .DATA_START(8'h10), .NUM_MSGS(0), .GAP_CKS(0), .ACK_CKS(3)
  ) u_dut_b (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(rdy[1]), .snd0_req_out(req[1]),
    .snd0_ack(ack[1]), .snd0_src(src[1]), .snd0_dst(dst[1]), .snd0_dat(dat[1]),
    .snd0_red(red[1]), .src_done(done[1]), .err0_error(err[1]), .err0_src(esrc[1]),
    .err0_dat(edat[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Receiver: forced level, immediate echo of req, or a randomly lagging, glitchy echo.
  always_comb begin
    for (int i = 0; i < 2; i++)
      ack[i] = force_en[i] ? force_val[i] : (imm[i] ? req[i] : ack_reg[i]);
  end

  initial begin
    ack_reg = '{1'b0, 1'b0};
    glitch  = '{1'b0, 1'b0};
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (glitch[i]) begin
          ack_reg[i] = !ack_reg[i];
          glitch[i]  = 1'b0;
        end else if (ack_reg[i] != req[i]) begin
          if ($urandom_range(0, 2) != 0) ack_reg[i] = req[i];
        end else if ($urandom_range(0, 9) == 0) begin
          ack_reg[i] = !ack_reg[i];
          glitch[i]  = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s[%0d] t=%0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Message lifecycle model: filtered ack, idle gap, request, release, completion.
  initial begin
    logic ck;
    forever begin
      @(posedge clk);
      if (rst) rel_cyc = 0;
      else     rel_cyc = rel_cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_ckd[i] = 1'b0; m_run[i] = 0; m_ph[i] = PH_INIT; m_idle[i] = 0;
          m_req[i] = 1'b0; m_dat[i] = 8'(p_start(i)); m_sent[i] = 0;
          m_done[i] = 1'b0; m_err[i] = 1'b0; m_edat[i] = 8'h00; m_rdy[i] = 1'b0;
          m_valid = 1'b1;
        end else begin
          ck = m_ckd[i];
          if (ack[i] == m_ckd[i]) m_run[i] = 0;
          else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= p_ack(i)) begin
              m_ckd[i] = ack[i];
              m_run[i] = 0;
            end
          end
          case (m_ph[i])
            PH_INIT: begin
              m_rdy[i] = 1'b1; m_idle[i] = 0; m_ph[i] = PH_IDLE;
            end
            PH_IDLE: begin
              if (ck) begin m_err[i] = 1'b1; m_edat[i] = m_dat[i]; end
              m_idle[i] = m_idle[i] + 1;
              if (m_idle[i] > p_gap(i) && !ck) begin m_req[i] = 1'b1; m_ph[i] = PH_REQ; end
            end
            PH_REQ: if (ck) begin m_req[i] = 1'b0; m_ph[i] = PH_REL; end
            PH_REL: if (!ck) begin
              m_dat[i]  = m_dat[i] + 8'd1;
              m_sent[i] = m_sent[i] + 1;
              m_idle[i] = 0;
              if (p_num(i) != 0 && m_sent[i] == p_num(i)) begin
                m_done[i] = 1'b1; m_ph[i] = PH_DONE;
              end else m_ph[i] = PH_IDLE;
            end
            default: if (ck) begin m_err[i] = 1'b1; m_edat[i] = m_dat[i]; end
          endcase
        end
      end
    end
  end

  // Every-cycle comparison of both sources against the model.
  initial begin
    logic [7:0] sum;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int i = 0; i < 2; i++) begin
          sum = 8'(p_dst(i) + p_my(i)) + m_dat[i];
          chk("ready", i, rdy[i], m_rdy[i]);
          chk("req", i, req[i], m_req[i]);
          chk("dat", i, dat[i], m_dat[i]);
          chk("red", i, red[i], sum[3:0]);
          chk("done", i, done[i], m_done[i]);
          chk("err", i, err[i], m_err[i]);
          chk("err_dat", i, edat[i], m_edat[i]);
          chk("src", i, src[i], p_my(i));
          chk("dst", i, dst[i], p_dst(i));
          chk("err_src", i, esrc[i], p_my(i));
        end
      end
    end
  end

  // Records req rising edges (cycle since reset release, payload) for literal checks.
  initial begin
    logic prev [2];
    prev = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin
        rise_a.delete(); rise_b.delete(); pay_a.delete(); rpay_a.delete();
        prev = '{1'b0, 1'b0};
      end else begin
        if (req[0] && !prev[0]) begin
          rise_a.push_back(rel_cyc); pay_a.push_back(dat[0]); rpay_a.push_back(red[0]);
        end
        if (req[1] && !prev[1]) rise_b.push_back(rel_cyc);
        prev[0] = req[0];
        prev[1] = req[1];
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  initial begin
    int k;
    logic [7:0] held;
    logic [7:0] exp_pay [4];
    logic [3:0] exp_red [4];
    exp_pay = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_red = '{4'h6, 4'h7, 4'h8, 4'h9};
    rst = 1'b1;
    imm = '{1'b1, 1'b1};
    force_en = '{1'b0, 1'b0};
    force_val = '{1'b0, 1'b0};

    repeat (3) step();
    chk("rst_req", 0, req[0], 0);
    chk("rst_dat", 0, dat[0], 8'hFE);
    chk("rst_red", 0, red[0], 4'h6);
    chk("rst_ready", 0, rdy[0], 0);
    chk("rst_done", 0, done[0], 0);
    chk("rst_err", 0, err[0], 0);
    chk("rst_err_dat", 0, edat[0], 0);
    chk("rst_dat", 1, dat[1], 8'h10);
    chk("rst_red", 1, red[1], 4'h3);

    // Ideal receivers: four-message stream on A, back-to-back period on B.
    rst = 1'b0;
    for (k = 0; k < 200 && done[0] !== 1'b1; k++) step();
    chk("a_done_reached", 0, done[0], 1);
    repeat (20) step();
    chk("a_req_count", 0, rise_a.size(), 4);
    if (rise_a.size() >= 1) chk("a_first_req_cycle", 0, rise_a[0], 8);
    for (int m = 0; m < 4 && m < rise_a.size(); m++) begin
      chk("a_payload", m, pay_a[m], exp_pay[m]);
      chk("a_red", m, rpay_a[m], exp_red[m]);
    end
    chk("b_req_count_min", 1, rise_b.size() >= 3, 1);
    if (rise_b.size() >= 3) begin
      chk("b_first_req_cycle", 1, rise_b[0], 2);
      chk("b_period_1", 1, rise_b[1] - rise_b[0], 9);
      chk("b_period_2", 1, rise_b[2] - rise_b[1], 9);
    end

    // Bouncy ack on B: a single-cycle pulse must be ignored.
    for (k = 0; k < 30 && req[1] !== 1'b0; k++) step();
    for (k = 0; k < 30 && req[1] !== 1'b1; k++) step();
    chk("b_req_seen", 1, req[1], 1);
    held = dat[1];
    force_en[1] = 1'b1; force_val[1] = 1'b0;
    step(); force_val[1] = 1'b1;
    step(); force_val[1] = 1'b0;
    step(); step();
    chk("b_bounce_req_held", 1, req[1], 1);
    chk("b_bounce_dat_held", 1, dat[1], held);
    force_val[1] = 1'b1;
    for (k = 0; k < 10 && req[1] !== 1'b0; k++) step();
    chk("b_real_ack_accepted", 1, req[1], 0);
    force_en[1] = 1'b0;

    // Reset while A has req raised.
    rst = 1'b1; step(); step(); rst = 1'b0;
    for (k = 0; k < 40 && req[0] !== 1'b1; k++) step();
    chk("a_req_before_reset", 0, req[0], 1);
    rst = 1'b1;
    step();
    chk("mid_rst_req", 0, req[0], 0);
    chk("mid_rst_dat", 0, dat[0], 8'hFE);
    chk("mid_rst_ready", 0, rdy[0], 0);
    rst = 1'b0;
    step();
    chk("ready_after_release", 0, rdy[0], 1);
    for (k = 0; k < 40 && req[0] !== 1'b1; k++) step();
    chk("a_req_after_reset", 0, req[0], 1);
    if (rise_a.size() >= 1) chk("a_first_req_after_reset", 0, rise_a[0], 8);

    // Spurious ack during A's gap.
    rst = 1'b1; step(); step(); rst = 1'b0;
    step(); step();
    force_en[0] = 1'b1; force_val[0] = 1'b1;
    repeat (5) step();
    force_en[0] = 1'b0;
    chk("spur_err", 0, err[0], 1);
    chk("spur_err_dat", 0, edat[0], 8'hFE);
    chk("spur_err_src", 0, esrc[0], 3);

    // Randomised receivers on both sources.
    imm = '{1'b0, 1'b0};
    repeat (1500) step();
    chk("err_sticky", 0, err[0], 1);
    chk("a_done_random", 0, done[0], 1);
    chk("b_never_done", 1, done[1], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
